// File: rtl/pix_pkg.sv
// Shared image-select codes, per-image grey levels and quantiser thresholds.
// The matching decoder uses the same levels to rebuild pixels.
package pix_pkg;

    localparam logic [2:0] SEL_LOGO  = 3'b111;
    localparam logic [2:0] SEL_CUBES = 3'b110;
    localparam logic [2:0] SEL_CHOCO = 3'b001;

    // logo palette
    localparam logic [7:0] LOGO_LVL0   = 8'h00;
    localparam logic [7:0] LOGO_LVL1   = 8'h64;
    localparam logic [7:0] LOGO_LVL2   = 8'hFF;
    localparam logic [7:0] LOGO_THR_LO = 8'h32;
    localparam logic [7:0] LOGO_THR_HI = 8'hB2;

    // cubes / choco_bar palette
    localparam logic [7:0] BLK_LVL0   = 8'h00;
    localparam logic [7:0] BLK_LVL1   = 8'h32;
    localparam logic [7:0] BLK_LVL2   = 8'h96;
    localparam logic [7:0] BLK_THR_LO = 8'h19;
    localparam logic [7:0] BLK_THR_HI = 8'h64;

    // 2-bit codes; 2'b10 is never produced
    localparam logic [1:0] CODE_LVL0 = 2'b00;
    localparam logic [1:0] CODE_LVL1 = 2'b01;
    localparam logic [1:0] CODE_LVL2 = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PACK = 1'b1
    } enc_state_e;

    function automatic logic sel_supported(input logic [2:0] sel);
        return (sel == SEL_LOGO) || (sel == SEL_CUBES) || (sel == SEL_CHOCO);
    endfunction

endpackage

// File: rtl/pix_encoder_if.sv
// Pixel-in / byte-out stream bundle of the pixel encoder, plus image select
// and the two sticky status flags.
interface pix_encoder_if;
    logic [2:0] sel;
    logic       in_valid;
    logic [7:0] in_pix;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       err_sel;
    logic       mismatch;

    // pixel source / byte sink side
    modport master (
        output sel, in_valid, in_pix, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, err_sel, mismatch
    );

    // encoder side
    modport slave (
        input  sel, in_valid, in_pix, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, err_sel, mismatch
    );
endinterface

// File: rtl/pix_quantizer.sv
// Maps a grayscale pixel to a 2-bit code using the thresholds of the selected
// image; exact_o flags a pixel that is precisely one of the image's levels.
// Unsupported selects give code 00 and exact_o low.
module pix_quantizer
    import pix_pkg::*;
(
    input  logic [7:0] pix_i,
    input  logic [2:0] sel_i,
    output logic [1:0] code_o,
    output logic       exact_o
);

    logic       known;
    logic [7:0] thr_lo, thr_hi, lvl0, lvl1, lvl2;

    // pick the palette for the selected image
    always_comb begin
        known  = 1'b1;
        thr_lo = BLK_THR_LO;
        thr_hi = BLK_THR_HI;
        lvl0   = BLK_LVL0;
        lvl1   = BLK_LVL1;
        lvl2   = BLK_LVL2;
        case (sel_i)
            SEL_LOGO: begin
                thr_lo = LOGO_THR_LO;
                thr_hi = LOGO_THR_HI;
                lvl0   = LOGO_LVL0;
                lvl1   = LOGO_LVL1;
                lvl2   = LOGO_LVL2;
            end
            SEL_CUBES, SEL_CHOCO: known = 1'b1;
            default:              known = 1'b0;
        endcase
    end

    // threshold compare and exact-level detect
    always_comb begin
        code_o = CODE_LVL0;
        if (known) begin
            if (pix_i < thr_lo)
                code_o = CODE_LVL0;
            else if (pix_i >= thr_hi)
                code_o = CODE_LVL2;
            else
                code_o = CODE_LVL1;
        end
        exact_o = known && ((pix_i == lvl0) || (pix_i == lvl1) || (pix_i == lvl2));
    end

endmodule

// File: rtl/pix_encoder.sv
// Packs quantised pixels four to a byte (earliest pixel in [1:0]) behind a
// single output register. Image select is latched on the first pixel of a
// frame. Optional macro PIX_ENCODER_EXACT_CHECK_EN enables the sticky
// mismatch flag for pixels that are not an exact palette level.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | between frames, next pixel latches sel
// ST_PACK | inside a frame, latched sel in use
module pix_encoder
    import pix_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    pix_encoder_if.slave bus
);

    enc_state_e state_q, state_d;
    logic [2:0] sel_q, sel_eff;
    logic [1:0] slot_q;
    logic [7:0] pack_q, pack_d;
    logic       out_valid_q, out_last_q;
    logic [7:0] out_data_q;
    logic       err_q;
    logic       in_ready, accept, byte_done;
    logic [1:0] code;
    logic       pix_exact;

    // one-deep output register: accept whenever it is empty or draining
    assign in_ready = !out_valid_q || bus.out_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // next state: a frame ends with the pixel carrying in_last
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !bus.in_last) state_d = ST_PACK;
            ST_PACK: if (accept &&  bus.in_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, byte completion, select in effect
    always_comb begin
        accept    = bus.in_valid && in_ready;
        byte_done = accept && ((slot_q == 2'd3) || bus.in_last);
        sel_eff   = (state_q == ST_IDLE) ? bus.sel : sel_q;
    end

    pix_quantizer u_quant (
        .pix_i  (bus.in_pix),
        .sel_i  (sel_eff),
        .code_o (code),
        .exact_o(pix_exact)
    );

    // insert the new code; unfilled slots stay zero since pack_q is cleared per byte
    always_comb begin
        pack_d = pack_q;
        pack_d[{slot_q, 1'b0} +: 2] = code;
    end

    // frame registers: latched select, slot counter, partial byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 3'b000;
            slot_q <= 2'd0;
            pack_q <= 8'h00;
        end else if (accept) begin
            if (state_q == ST_IDLE) sel_q <= bus.sel;
            if (byte_done) begin
                slot_q <= 2'd0;
                pack_q <= 8'h00;
            end else begin
                slot_q <= slot_q + 2'd1;
                pack_q <= pack_d;
            end
        end
    end

    // output register: load on completion (even while draining), clear on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else if (byte_done) begin
            out_valid_q <= 1'b1;
            out_data_q  <= pack_d;
            out_last_q  <= bus.in_last;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // sticky unsupported-select flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 err_q <= 1'b0;
        else if (accept && !sel_supported(sel_eff)) err_q <= 1'b1;
    end

`ifdef PIX_ENCODER_EXACT_CHECK_EN
    logic mismatch_q;

    // sticky flag for a pixel that is not an exact palette level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   mismatch_q <= 1'b0;
        else if (accept && !pix_exact) mismatch_q <= 1'b1;
    end

    assign bus.mismatch = mismatch_q;
`else
    logic unused_exact;
    assign unused_exact = pix_exact;
    assign bus.mismatch = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.err_sel   = err_q;

endmodule
